// File: rtl/channel_fallback_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | qos_defs : shared widths and FSM encodings for channel_fallback |
// | Revision : 1.0                                                  |
// +----------------------------------------------------------------+
package qos_defs;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int ERR_W  = 8;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PEND = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/channel_fallback_ctrl_err_counter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | err_counter : saturating per-channel error counter, clear wins  |
// | Revision    : 1.0                                               |
// +----------------------------------------------------------------+
module err_counter
  import qos_defs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe_i,
  input  logic             clear_i,
  output logic [ERR_W-1:0] count_o
);

  logic [ERR_W-1:0] count_q;
  logic [ERR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (strobe_i && (count_q != '1)) begin
      count_d = count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/channel_fallback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------+
// | channel_fallback_ctrl : TS input channel selection with fallback|
// | Revision              : 1.0                                     |
// +----------------------------------------------------------------+
module channel_fallback_ctrl
  import qos_defs::*;
#(
  parameter logic [ERR_W-1:0] ERR_THRESH = 8'd16,
  parameter int               HOLDOFF    = 1024,
  parameter int               TIMER_W    = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fallback_enable_i,
  input  logic                manual_enable_i,
  input  logic [CH_W-1:0]     manual_channel_i,
  input  logic [2*NUM_CH-1:0] channel_priority_i,
  input  logic [TIMER_W-1:0]  reset_timer_i,
  input  logic [NUM_CH-1:0]   signal_present_i,
  input  logic [NUM_CH-1:0]   error_strobe_i,
  input  logic                pkt_sync_i,
  output logic [CH_W-1:0]     active_channel_o,
  output logic [ERR_W-1:0]    error_count_ch0_o,
  output logic [ERR_W-1:0]    error_count_ch1_o,
  output logic [ERR_W-1:0]    error_count_ch2_o,
  output logic [ERR_W-1:0]    error_count_ch3_o,
  output logic                switch_event_o,
  output logic                all_lost_o
);

  localparam int               HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     active_q, active_d;
  logic [CH_W-1:0]     pend_q, pend_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TIMER_W-1:0]  window_q, window_d;
  logic                switch_q, switch_d;
  logic                all_lost_q, all_lost_d;

  logic                win_clear;
  logic [NUM_CH-1:0]   healthy;
  logic [CH_W-1:0]     target;
  logic                fallback_lost;
  logic [ERR_W-1:0]    err_count [NUM_CH];

  always_comb begin
    window_d  = window_q;
    win_clear = 1'b0;
    if (reset_timer_i != '0) begin
      if (window_q == reset_timer_i - TIMER_W'(1)) begin
        window_d  = '0;
        win_clear = 1'b1;
      end else begin
        window_d  = window_q + TIMER_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_err
    err_counter u_err (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe_i (error_strobe_i[i]),
      .clear_i  (win_clear),
      .count_o  (err_count[i])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      healthy[i] = signal_present_i[i] && (err_count[i] < ERR_THRESH);
    end
  end

  // Scan lowest priority first so the highest-ranked healthy channel wins.
  always_comb begin
    target        = active_q;
    fallback_lost = 1'b0;
    if (manual_enable_i) begin
      target = manual_channel_i;
    end else if (fallback_enable_i) begin
      fallback_lost = 1'b1;
      for (int r = NUM_CH - 1; r >= 0; r--) begin
        if (healthy[channel_priority_i[CH_W*r +: CH_W]]) begin
          target        = channel_priority_i[CH_W*r +: CH_W];
          fallback_lost = 1'b0;
        end
      end
    end else begin
      target = channel_priority_i[CH_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pend_d     = pend_q;
    hold_d     = hold_q;
    switch_d   = 1'b0;
    all_lost_d = fallback_lost;
    case (state_q)
      S_RUN: begin
        if (target != active_q) begin
          state_d = S_PEND;
          pend_d  = target;
        end
      end
      S_PEND: begin
        pend_d = target;
        if (target == active_q) begin
          state_d = S_RUN;
        end else if (pkt_sync_i) begin
          active_d = pend_q;
          switch_d = 1'b1;
          hold_d   = HOLD_LOAD;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        // Operator overrides are honoured even inside the anti-flap window.
        if (manual_enable_i && (target != active_q)) begin
          state_d = S_PEND;
          pend_d  = target;
        end else if (hold_q == '0) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      active_q   <= '0;
      pend_q     <= '0;
      hold_q     <= '0;
      window_q   <= '0;
      switch_q   <= 1'b0;
      all_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      window_q   <= window_d;
      switch_q   <= switch_d;
      all_lost_q <= all_lost_d;
    end
  end

  assign active_channel_o  = active_q;
  assign switch_event_o    = switch_q;
  assign all_lost_o        = all_lost_q;
  assign error_count_ch0_o = err_count[0];
  assign error_count_ch1_o = err_count[1];
  assign error_count_ch2_o = err_count[2];
  assign error_count_ch3_o = err_count[3];

endmodule
`default_nettype wire

// File: tb/tb_channel_fallback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_channel_fallback_ctrl : directed bench with switch scoreboard|
// | Revision                 : 1.0                                  |
// +----------------------------------------------------------------+
module tb_channel_fallback_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fallback_enable;
  logic        manual_enable;
  logic [1:0]  manual_channel;
  logic [7:0]  channel_priority;
  logic [19:0] reset_timer;
  logic [3:0]  signal_present;
  logic [3:0]  error_strobe;
  logic        pkt_sync;
  logic [1:0]  active_channel;
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;
  logic        switch_event;
  logic        all_lost;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_q [$];
  logic [1:0]  mon_exp;

  channel_fallback_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fallback_enable_i  (fallback_enable),
    .manual_enable_i    (manual_enable),
    .manual_channel_i   (manual_channel),
    .channel_priority_i (channel_priority),
    .reset_timer_i      (reset_timer),
    .signal_present_i   (signal_present),
    .error_strobe_i     (error_strobe),
    .pkt_sync_i         (pkt_sync),
    .active_channel_o   (active_channel),
    .error_count_ch0_o  (cnt0),
    .error_count_ch1_o  (cnt1),
    .error_count_ch2_o  (cnt2),
    .error_count_ch3_o  (cnt3),
    .switch_event_o     (switch_event),
    .all_lost_o         (all_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every switch_event must match the next expected channel in the queue.
  always @(negedge clk) begin
    if (switch_event) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_switch: active=%0d, expected no switch", active_channel);
      end else begin
        mon_exp = exp_q.pop_front();
        if (active_channel != mon_exp) begin
          n_fail++;
          $display("FAIL switch_target: active=%0d expected=%0d", active_channel, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_pulse();
    pkt_sync = 1'b1;
    tick(1);
    pkt_sync = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; fallback_enable = 1'b0; manual_enable = 1'b0; manual_channel = 2'd0;
    channel_priority = 8'h00; reset_timer = 20'd0; signal_present = 4'h0;
    error_strobe = 4'h0; pkt_sync = 1'b0;
    tick(3);
    check("reset_active", active_channel, 0);
    check("reset_count0", cnt0, 0);
    check("reset_switch", switch_event, 0);
    check("reset_all_lost", all_lost, 0);
    rst_n = 1'b1;

    // 1: rank0 = ch3, everything healthy
    channel_priority = 8'b00_01_10_11; fallback_enable = 1'b1; signal_present = 4'hf;
    tick(3);
    check("t1_no_switch_before_sync", active_channel, 0);
    exp_q.push_back(2'd3);
    sync_pulse();
    tick(2);
    check("t1_active", active_channel, 3);

    // 2: lose ch3 after hold-off, fall to rank1 = ch2
    tick(1100);
    signal_present = 4'b0111;
    tick(5);
    check("t2_wait_for_sync", active_channel, 3);
    exp_q.push_back(2'd2);
    sync_pulse();
    tick(2);
    check("t2_active", active_channel, 2);
    check("t2_all_lost", all_lost, 0);

    // 3: error threshold on ch2, then saturation
    tick(1100);
    error_strobe = 4'b0100;
    tick(15);
    error_strobe = 4'b0000;
    check("t3_count15", cnt2, 15);
    sync_pulse();
    tick(2);
    check("t3_still_ch2", active_channel, 2);
    error_strobe = 4'b0100;
    tick(1);
    error_strobe = 4'b0000;
    check("t3_count16", cnt2, 16);
    tick(2);
    exp_q.push_back(2'd1);
    sync_pulse();
    tick(1);
    check("t3_active", active_channel, 1);
    error_strobe = 4'b0100;
    tick(300);
    error_strobe = 4'b0000;
    check("t3_saturate", cnt2, 255);
    check("t3_ch1_count", cnt1, 0);

    // 4: window clear, clear beats a same-cycle strobe
    reset_timer = 20'd100;
    tick(99);
    check("t4_before_clear", cnt2, 255);
    tick(1);
    check("t4_cleared", cnt2, 0);
    error_strobe = 4'b0001;
    tick(99);
    check("t4_ch0_99", cnt0, 99);
    tick(1);
    check("t4_clear_beats_strobe", cnt0, 0);
    error_strobe = 4'b0000;
    reset_timer = 20'd0;

    // 5: manual override inside hold-off, then a cancelled request
    manual_enable = 1'b1; manual_channel = 2'd0;
    tick(2);
    check("t5_wait_for_sync", active_channel, 1);
    exp_q.push_back(2'd0);
    sync_pulse();
    tick(1);
    check("t5_active", active_channel, 0);
    manual_channel = 2'd2;
    tick(2);
    manual_channel = 2'd0;
    tick(2);
    sync_pulse();
    tick(2);
    check("t5_cancel_no_switch", active_channel, 0);

    // 6: total loss, then reset while a switch is pending
    manual_enable = 1'b0; signal_present = 4'h0;
    tick(2);
    check("t6_all_lost", all_lost, 1);
    sync_pulse();
    tick(1);
    check("t6_active_held", active_channel, 0);
    signal_present = 4'hf; error_strobe = 4'b0010;
    tick(3);
    error_strobe = 4'b0000;
    check("t6_ch1_count", cnt1, 3);
    check("t6_all_lost_clear", all_lost, 0);
    rst_n = 1'b0; pkt_sync = 1'b1;
    tick(1);
    check("t6_rst_active", active_channel, 0);
    check("t6_rst_count", cnt1, 0);
    rst_n = 1'b1;
    tick(1);
    pkt_sync = 1'b0;
    tick(2);
    check("t6_entry_sync_ignored", active_channel, 0);
    exp_q.push_back(2'd3);
    sync_pulse();
    tick(2);
    check("t6_active", active_channel, 3);

    tick(3);
    check("pending_switches", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
